// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and default sizing.
// No logic of its own; no latency or backpressure.
package mult_pkg;
    localparam int DEF_WIDTH = 12;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;
endpackage

// File: rtl/mult_datapath.sv
// Multiplicand/multiplier/accumulator registers and adder; one partial product per step.
// Latency is set by the controller; no backpressure, load and step are obeyed every cycle.
module mult_datapath #(
    parameter int WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    output logic [2*WIDTH-1:0] acc_nxt
);
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] addend;

    // acc_nxt is exposed so the controller can capture the final sum on the last step
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign acc_nxt = acc_q + addend;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, x_in};
            mplier_d = y_in;
            acc_d    = '0;
        end else if (step) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/unsigned_mult_core.sv
// Iterative radix-2 unsigned multiplier; WIDTH-cycle latency (1 cycle for zero operands with MULT_ZERO_BYPASS_EN).
// No backpressure: start is only taken in IDLE/DONE and ignored while busy.
module unsigned_mult_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   x_parallel,
    input  logic [WIDTH-1:0]   y_parallel,
    input  logic               start,
    output logic [2*WIDTH-1:0] z_parallel,
    output logic               sz,
    output logic               busy
);
    localparam int CNT_W = (WIDTH == DEF_WIDTH) ? DEF_CNT_W : $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               sz_q, sz_d;
    logic               busy_q, busy_d;
    logic               load, step;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               skip_busy;

`ifdef MULT_ZERO_BYPASS_EN
    assign skip_busy = (x_parallel == '0) || (y_parallel == '0);
`else
    assign skip_busy = 1'b0;
`endif

    mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .x_in    (x_parallel),
        .y_in    (y_parallel),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        sz_d    = sz_q;
        busy_d  = busy_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    z_d   = '0;
                    sz_d  = 1'b0;
                    // a zero-operand bypass parks in DONE with sz low for one cycle
                    if (skip_busy) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end
                end else begin
                    sz_d = (state_q == ST_DONE);
                end
            end
            ST_BUSY: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    z_d     = acc_nxt;
                    state_d = ST_DONE;
                    sz_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sz_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            z_q     <= '0;
            sz_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            sz_q    <= sz_d;
            busy_q  <= busy_d;
        end
    end

    assign z_parallel = z_q;
    assign sz         = sz_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_unsigned_mult_core.sv
// Directed + randomized checks of unsigned_mult_core against plain-arithmetic expectations.
module tb_unsigned_mult_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] xp = '0;
    logic [11:0] yp = '0;
    logic        start = 1'b0;
    logic [23:0] z;
    logic        sz;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    unsigned_mult_core dut (
        .clk        (clk),
        .reset      (reset),
        .x_parallel (xp),
        .y_parallel (yp),
        .start      (start),
        .z_parallel (z),
        .sz         (sz),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: product is plain a*b, ready WIDTH edges after the accepted start
    // (one edge for a zero operand when the bypass is built in).
    task automatic do_mult(input logic [11:0] a, input logic [11:0] b,
                           input int interfere_at, input string tag);
        logic [23:0] exp_z;
        int exp_lat;
        int lat;
        int bcnt;
        exp_z   = {12'd0, a} * {12'd0, b};
        exp_lat = 12;
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 12'd0 || b == 12'd0) exp_lat = 1;
`endif
        xp = a;
        yp = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        xp = 12'($urandom);
        yp = 12'($urandom);
        lat = 0;
        check({tag, " z_cleared"}, 32'(z), 32'd0);
        check({tag, " sz_low"}, 32'(sz), 32'd0);
        bcnt = busy ? 1 : 0;
        while (!sz && lat < 40) begin
            if (lat == interfere_at) begin
                start = 1'b1;
                xp = 12'($urandom_range(1, 4095));
                yp = 12'($urandom_range(1, 4095));
            end
            tick();
            start = 1'b0;
            lat++;
            if (!sz && busy) bcnt++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " product"}, 32'(z), 32'(exp_z));
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " busy_cycles"}, 32'(bcnt), (exp_lat == 1) ? 32'd0 : 32'd12);
    endtask

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;
        int k;

        // reset state
        reset = 1'b0;
        xp = 12'hABC;
        yp = 12'h123;
        start = 1'b1;
        tick();
        tick();
        check("rst z", 32'(z), 32'd0);
        check("rst sz", 32'(sz), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("idle sz", 32'(sz), 32'd0);

        do_mult(12'd3, 12'd5, -1, "m3x5");
        tick();
        tick();
        check("done hold sz", 32'(sz), 32'd1);
        check("done hold z", 32'(z), 32'h00000F);

        do_mult(12'hFFF, 12'hFFF, -1, "mFFFxFFF");
        do_mult(12'h800, 12'h002, -1, "m800x002");

        // start pulsed in BUSY cycle 5 is ignored
        do_mult(12'd25, 12'd40, 5, "ignore");
        do_mult(12'h00A, 12'h00B, -1, "b2b");

        // reset during BUSY cycle 6
        xp = 12'h321;
        yp = 12'h456;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst sz", 32'(sz), 32'd0);
        check("midrst z", 32'(z), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        tick();
        check("midrst idle", 32'(busy) + 32'(sz), 32'd0);
        do_mult(12'h321, 12'h456, -1, "after_rst");

        do_mult(12'd0, 12'h123, -1, "zero_x");
        do_mult(12'h123, 12'd0, -1, "zero_y");

        // randomized operands, occasionally zero
        for (int i = 0; i < 8; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            if ($urandom_range(0, 4) == 0) ra = 12'd0;
            do_mult(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, "rand");
        end

        // start held high: sz shows 12 low, 1 high, repeating
        xp = 12'd7;
        yp = 12'd9;
        start = 1'b1;
        tick();
        for (k = 1; k <= 40; k++) begin
            tick();
            check("held sz", 32'(sz), (k % 13 == 12) ? 32'd1 : 32'd0);
            if (k % 13 == 12) check("held z", 32'(z), 32'h00003F);
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/unsigned_mult_core.md
# unsigned_mult_core

Iterative radix-2 shift-add unsigned multiplier that forms the 24-bit product consumed by `shift_out`. It accepts two parallel 12-bit operands on a `start` pulse and computes the product over WIDTH cycles. It presents the result on `z_parallel` and raises `sz`. `shift_out` loads on the low-to-high edge of `sz`, so `sz` is low while a computation is in progress and high once the product is valid.

## Interface
- WIDTH, 12, operand width; product width is 2*WIDTH.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising `clk`.
- x_parallel  input  WIDTH  multiplicand; sampled only on an accepted `start`.
- y_parallel  input  WIDTH  multiplier; sampled only on an accepted `start`.
- start  input  1  request to multiply; level-sampled each cycle.
- z_parallel  output  2*WIDTH  product; registered; stable from `sz` rise until the next accepted `start`.
- sz  output  1  product valid; low during IDLE and BUSY, high in DONE.
- busy  output  1  high only in BUSY.

## Operation
- States:
  - IDLE: after reset.
  - BUSY: computing.
  - DONE: result held.
- Reset (reset=0 at a clock edge) sets the following, overriding any other event:
  - state=IDLE
  - z_parallel=0, sz=0, busy=0
  - internal accumulator, operand registers and bit counter all 0
- Start acceptance:
  - `start`=1 in IDLE or DONE is accepted.
  - On acceptance: latch x into a 2*WIDTH multiplicand register (zero-extended) and y into the multiplier shift register; clear the accumulator; count=0; go to BUSY; drive `sz`=0.
  - `z_parallel` is cleared to 0 on acceptance.
- BUSY, each cycle:
  - If the multiplier LSB=1, the accumulator gains the multiplicand (2*WIDTH-bit add; no overflow is possible).
  - The multiplicand shifts left 1 and the multiplier shifts right 1.
  - count increments.
  - On the cycle where count reaches WIDTH-1, the final accumulator value is written to `z_parallel`, state goes to DONE, and `sz` goes 1.
- `start` during BUSY is ignored; there is no queueing.
- DONE holds `z_parallel` and `sz`=1 indefinitely.
- Back-to-back: `start` in DONE drops `sz` for at least WIDTH cycles, which guarantees `shift_out` a fresh rising edge.
- `start` held high continuously re-triggers on every entry to DONE; DONE then lasts exactly one cycle.

## Timing
- Accepted `start` at edge N: `busy`=1 and `sz`=0 from after edge N.
- Product valid, `sz`=1, `busy`=0 after edge N+WIDTH. Latency is WIDTH cycles (12 by default).
- Minimum `sz` low time: WIDTH cycles; `sz` high lasts at least 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Reset asserted mid-BUSY: IDLE at the next edge; partial result discarded; `sz` stays 0.

## Configuration
- `MULT_ZERO_BYPASS_EN` defined:
  - If latched x==0 or y==0, the accepted `start` goes directly to DONE.
  - `z_parallel`=0 and `sz`=1 after edge N+1; latency 1 cycle; `busy` never asserts.
  - `sz` is low for only the one cycle after edge N.
- `MULT_ZERO_BYPASS_EN` undefined:
  - Zero operands take the full WIDTH cycles like any other operand.

## Structure
- Shared package `mult_pkg`:
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10
  - default WIDTH=12
  - counter width localparam $clog2(WIDTH)
- One sub-module, `mult_datapath`, holds the multiplicand, multiplier and accumulator registers plus the adder. It takes load/step controls and reports the product.
- The top level holds the FSM, the counter, and the output registers.

## Test plan
- 3 * 5 with start at edge N: `sz` low N..N+11, high after N+12, `z_parallel`=24'h00000F; `busy` high for exactly 12 cycles.
- 12'hFFF * 12'hFFF: `z_parallel`=24'hFFE001; 12'h800 * 12'h002: `z_parallel`=24'h001000.
- Pulse `start` again at cycle 5 of BUSY with different operands: ignored, first product delivered on schedule. Then `start` in DONE with 12'h00A * 12'h00B: `sz` falls, and after 12 cycles rises with 24'h00006E.
- Reset=0 at BUSY cycle 6: next cycle IDLE, `sz`=0, `z_parallel`=0, `busy`=0. A new `start` then completes normally.
- 0 * 12'h123:
  - with `MULT_ZERO_BYPASS_EN`: `sz`=1 and `z_parallel`=0 after one cycle.
  - without it: after 12 cycles.
- `start` held high for 40 cycles with constant 7 * 9: `sz` pattern repeats 12 low, 1 high; `z_parallel`=24'h00003F each time `sz`=1.
